// File: rtl/cpu_control.sv
// Multi-cycle control sequencer for the mos6502 datapath: decodes IR, steps the
// phase FSM and drives every datapath select, with rdy stalling and a retire counter.
package cpu_control_pkg;

    typedef enum logic [7:0] {
        OP_ORA_IMM = 8'h09,
        OP_AND_IMM = 8'h29,
        OP_EOR_IMM = 8'h49,
        OP_JMP_ABS = 8'h4C,
        OP_ADC_IMM = 8'h69,
        OP_STA_ABS = 8'h8D,
        OP_LDA_IMM = 8'hA9,
        OP_LDA_ABS = 8'hAD,
        OP_BNE     = 8'hD0,
        OP_INX     = 8'hE8,
        OP_SBC_IMM = 8'hE9,
        OP_NOP     = 8'hEA,
        OP_BEQ     = 8'hF0
    } opc_t;

    typedef enum logic {NOLOAD = 1'b0, LOAD = 1'b1} il_t;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} mw_t;
    typedef enum logic {PC_ADDR = 1'b0, A_ADDR = 1'b1} mm_t;
    typedef enum logic [1:0] {HOLD = 2'd0, INC = 2'd1, REL = 2'd2, ABS = 2'd3} ps_t;
    typedef enum logic [2:0] {
        ANOP = 3'd0,
        AADD = 3'd1,
        ASUB = 3'd2,
        AAND = 3'd3,
        AEOR = 3'd4,
        AORA = 3'd5,
        AINC = 3'd6
    } alu_t;
    typedef enum logic {EX0 = 1'b0, INF = 1'b1} state_t;

endpackage

module cpu_control
    import cpu_control_pkg::*;
#(
    parameter int RST_VECTOR_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [7:0]  ir,
    input  logic        zflag,
    output logic        il,
    output logic        mw,
    output logic        mm,
    output logic [1:0]  ps,
    output logic [2:0]  alu_op,
    output logic        a_sel,
    output logic        a_ld,
    output logic        x_ld,
    output logic        flags_ld,
    output logic        adl_ld,
    output logic        adh_ld,
    output logic        state,
    output logic        retired,
    output logic [15:0] icount
);

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_FETCH = 3'd1,
        S_EX    = 3'd2,
        S_ADL   = 3'd3,
        S_ADH   = 3'd4,
        S_MEM   = 3'd5
    } phase_t;

    localparam logic [1:0] WAIT_LAST = 2'(RST_VECTOR_WAIT - 1);

    phase_t      phase_r;
    phase_t      phase_tgt_s;
    logic [1:0]  wait_cnt_r;
    logic [1:0]  wait_tgt_s;
    logic [15:0] icount_r;

    il_t  il_raw_s;
    mw_t  mw_s;
    mm_t  mm_s;
    ps_t  ps_raw_s;
    alu_t alu_s;
    logic a_sel_s;
    logic a_ld_raw_s;
    logic x_ld_raw_s;
    logic flags_ld_raw_s;
    logic adl_ld_raw_s;
    logic adh_ld_raw_s;
    logic retired_raw_s;

    function automatic alu_t imm_alu(input logic [7:0] op);
        alu_t f;
        case (op)
            OP_ADC_IMM: f = AADD;
            OP_SBC_IMM: f = ASUB;
            OP_AND_IMM: f = AAND;
            OP_EOR_IMM: f = AEOR;
            OP_ORA_IMM: f = AORA;
            default:    f = ANOP;
        endcase
        return f;
    endfunction

    function automatic logic branch_taken(input logic [7:0] op, input logic z);
        logic t;
        if (op == OP_BNE) begin
            t = ~z;
        end else begin
            t = z;
        end
        return t;
    endfunction

    // Phase decode: unstalled outputs and the phase to advance to
    always_comb begin
        il_raw_s       = NOLOAD;
        mw_s           = READ;
        mm_s           = PC_ADDR;
        ps_raw_s       = HOLD;
        alu_s          = ANOP;
        a_sel_s        = 1'b0;
        a_ld_raw_s     = 1'b0;
        x_ld_raw_s     = 1'b0;
        flags_ld_raw_s = 1'b0;
        adl_ld_raw_s   = 1'b0;
        adh_ld_raw_s   = 1'b0;
        retired_raw_s  = 1'b0;
        phase_tgt_s    = phase_r;
        wait_tgt_s     = wait_cnt_r;
        case (phase_r)
            S_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    phase_tgt_s = S_FETCH;
                    wait_tgt_s  = 2'd0;
                end else begin
                    wait_tgt_s  = wait_cnt_r + 2'd1;
                end
            end
            S_FETCH: begin
                il_raw_s    = LOAD;
                ps_raw_s    = INC;
                phase_tgt_s = S_EX;
            end
            S_EX: begin
                case (ir)
                    OP_LDA_IMM, OP_ADC_IMM, OP_SBC_IMM,
                    OP_AND_IMM, OP_EOR_IMM, OP_ORA_IMM: begin
                        ps_raw_s       = INC;
                        a_ld_raw_s     = 1'b1;
                        flags_ld_raw_s = 1'b1;
                        a_sel_s        = (ir == OP_LDA_IMM);
                        alu_s          = imm_alu(ir);
                        retired_raw_s  = 1'b1;
                        phase_tgt_s    = S_FETCH;
                    end
                    OP_INX: begin
                        alu_s          = AINC;
                        x_ld_raw_s     = 1'b1;
                        flags_ld_raw_s = 1'b1;
                        retired_raw_s  = 1'b1;
                        phase_tgt_s    = S_FETCH;
                    end
                    OP_BNE, OP_BEQ: begin
                        ps_raw_s      = branch_taken(ir, zflag) ? REL : INC;
                        retired_raw_s = 1'b1;
                        phase_tgt_s   = S_FETCH;
                    end
                    // Absolute forms spend S_EX quiet while the operand bytes are still ahead
                    OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: begin
                        phase_tgt_s = S_ADL;
                    end
                    default: begin
                        retired_raw_s = 1'b1;
                        phase_tgt_s   = S_FETCH;
                    end
                endcase
            end
            S_ADL: begin
                adl_ld_raw_s = 1'b1;
                ps_raw_s     = INC;
                phase_tgt_s  = S_ADH;
            end
            S_ADH: begin
                if (ir == OP_JMP_ABS) begin
                    ps_raw_s      = ABS;
                    retired_raw_s = 1'b1;
                    phase_tgt_s   = S_FETCH;
                end else begin
                    adh_ld_raw_s  = 1'b1;
                    ps_raw_s      = INC;
                    phase_tgt_s   = S_MEM;
                end
            end
            S_MEM: begin
                mm_s          = A_ADDR;
                retired_raw_s = 1'b1;
                phase_tgt_s   = S_FETCH;
                if (ir == OP_LDA_ABS) begin
                    a_sel_s        = 1'b1;
                    a_ld_raw_s     = 1'b1;
                    flags_ld_raw_s = 1'b1;
                end else if (ir == OP_STA_ABS) begin
                    mw_s = WRITE;
                end else begin
                    mw_s = READ;
                end
            end
            default: begin
                phase_tgt_s = S_WAIT;
                wait_tgt_s  = 2'd0;
            end
        endcase
    end

    // Stall gating: bus selects stay stable, every state-changing strobe is dropped
    always_comb begin
        mw       = mw_s;
        mm       = mm_s;
        alu_op   = alu_s;
        a_sel    = a_sel_s;
        state    = (phase_r == S_FETCH) ? INF : EX0;
        il       = NOLOAD;
        ps       = HOLD;
        a_ld     = 1'b0;
        x_ld     = 1'b0;
        flags_ld = 1'b0;
        adl_ld   = 1'b0;
        adh_ld   = 1'b0;
        retired  = 1'b0;
        if (rdy) begin
            il       = il_raw_s;
            ps       = ps_raw_s;
            a_ld     = a_ld_raw_s;
            x_ld     = x_ld_raw_s;
            flags_ld = flags_ld_raw_s;
            adl_ld   = adl_ld_raw_s;
            adh_ld   = adh_ld_raw_s;
            retired  = retired_raw_s;
        end else begin
            il       = NOLOAD;
            ps       = HOLD;
        end
    end

    // Phase register and post-reset wait counter, held while rdy is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r    <= S_WAIT;
            wait_cnt_r <= 2'd0;
        end else if (rdy) begin
            phase_r    <= phase_tgt_s;
            wait_cnt_r <= wait_tgt_s;
        end else begin
            phase_r    <= phase_r;
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Retired-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icount_r <= 16'd0;
        end else if (retired) begin
            icount_r <= icount_r + 16'd1;
        end else begin
            icount_r <= icount_r;
        end
    end

    assign icount = icount_r;

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: vector table, hand-written corner sequences
// and randomized instructions with stalls against a per-instruction cycle model.
module tb_cpu_control;
    import cpu_control_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, rdy, zflag;
    logic [7:0]  ir;
    logic        il, mw, mm, a_sel, a_ld, x_ld, flags_ld, adl_ld, adh_ld, state, retired;
    logic [1:0]  ps;
    logic [2:0]  alu_op;
    logic [15:0] icount;

    always #5 clk = ~clk;

    cpu_control #(.RST_VECTOR_WAIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .ir(ir), .zflag(zflag),
        .il(il), .mw(mw), .mm(mm), .ps(ps), .alu_op(alu_op), .a_sel(a_sel),
        .a_ld(a_ld), .x_ld(x_ld), .flags_ld(flags_ld), .adl_ld(adl_ld),
        .adh_ld(adh_ld), .state(state), .retired(retired), .icount(icount)
    );

    typedef struct packed {
        logic       il;
        logic       mw;
        logic       mm;
        logic [1:0] ps;
        logic [2:0] alu;
        logic       a_sel;
        logic       a_ld;
        logic       x_ld;
        logic       fl;
        logic       adl;
        logic       adh;
        logic       st;
        logic       ret;
    } outv_t;

    typedef struct {
        logic [7:0] op;
        logic       z;
        outv_t      ex;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_icount = 16'd0;

    function automatic outv_t mkv(input logic [1:0] ps_v, input logic [2:0] alu_v,
                                  input logic a_sel_v, input logic a_ld_v, input logic x_ld_v,
                                  input logic fl_v, input logic ret_v);
        outv_t v;
        v       = '0;
        v.ps    = ps_v;
        v.alu   = alu_v;
        v.a_sel = a_sel_v;
        v.a_ld  = a_ld_v;
        v.x_ld  = x_ld_v;
        v.fl    = fl_v;
        v.ret   = ret_v;
        return v;
    endfunction

    function automatic outv_t stall_mask(input outv_t v);
        outv_t m;
        m      = v;
        m.il   = 1'b0;
        m.ps   = 2'd0;
        m.a_ld = 1'b0;
        m.x_ld = 1'b0;
        m.fl   = 1'b0;
        m.adl  = 1'b0;
        m.adh  = 1'b0;
        m.ret  = 1'b0;
        return m;
    endfunction

    // Reference: the bus cycles one instruction produces, fetch first
    function automatic int model(input logic [7:0] op, input logic z, output outv_t seq [5]);
        int n;
        for (int i = 0; i < 5; i++) seq[i] = '0;
        seq[0].il = LOAD;
        seq[0].ps = INC;
        seq[0].st = INF;
        n = 2;
        case (op)
            8'hA9: seq[1] = mkv(INC, ANOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            8'h69: seq[1] = mkv(INC, AADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            8'hE9: seq[1] = mkv(INC, ASUB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            8'h29: seq[1] = mkv(INC, AAND, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            8'h49: seq[1] = mkv(INC, AEOR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            8'h09: seq[1] = mkv(INC, AORA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            8'hE8: seq[1] = mkv(HOLD, AINC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            8'hD0: seq[1] = mkv(z ? INC : REL, ANOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            8'hF0: seq[1] = mkv(z ? REL : INC, ANOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            8'h4C, 8'hAD, 8'h8D: begin
                seq[2].adl = 1'b1;
                seq[2].ps  = INC;
                if (op == 8'h4C) begin
                    seq[3].ps  = ABS;
                    seq[3].ret = 1'b1;
                    n = 4;
                end else begin
                    seq[3].adh = 1'b1;
                    seq[3].ps  = INC;
                    seq[4].mm  = A_ADDR;
                    seq[4].ret = 1'b1;
                    if (op == 8'hAD) begin
                        seq[4].a_sel = 1'b1;
                        seq[4].a_ld  = 1'b1;
                        seq[4].fl    = 1'b1;
                    end else begin
                        seq[4].mw = WRITE;
                    end
                    n = 5;
                end
            end
            default: seq[1].ret = 1'b1;
        endcase
        return n;
    endfunction

    task automatic check_v(input string nm, input outv_t e);
        outv_t act;
        act = {il, mw, mm, ps, alu_op, a_sel, a_ld, x_ld, flags_ld, adl_ld, adh_ld, state, retired};
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s outputs act=%h exp=%h (il mw mm ps alu a_sel a_ld x_ld fl adl adh st ret)",
                     nm, act, e);
        end
    endtask

    task automatic check_c(input string nm, input logic [15:0] e);
        checks++;
        if (icount !== e) begin
            failures++;
            $display("FAIL %s icount act=%h exp=%h", nm, icount, e);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare shortly after
    task automatic cyc(input logic r, input logic [7:0] i, input logic z, input outv_t e,
                       input string nm);
        @(negedge clk);
        rdy   = r;
        ir    = i;
        zflag = z;
        #1;
        check_c(nm, exp_icount);
        check_v(nm, e);
        if (e.ret) exp_icount = exp_icount + 16'd1;
    endtask

    task automatic run_instr(input logic [7:0] op, input logic z, input int stall_pct,
                             input string nm);
        outv_t seq [5];
        int    n;
        n = model(op, z, seq);
        for (int k = 0; k < n; k++) begin
            while (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct)
                cyc(1'b0, (k == 0) ? 8'($urandom) : op, z, stall_mask(seq[k]), nm);
            cyc(1'b1, (k == 0) ? 8'($urandom) : op, z, seq[k], nm);
        end
    endtask

    vec_t       tbl [16];
    logic [7:0] ops [13];

    initial begin
        outv_t seq [5];
        int    n;
        logic [7:0] rop;

        tbl[0]  = '{8'hA9, 1'b0, mkv(INC, ANOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[1]  = '{8'h69, 1'b0, mkv(INC, AADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[2]  = '{8'hE9, 1'b1, mkv(INC, ASUB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[3]  = '{8'h29, 1'b0, mkv(INC, AAND, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[4]  = '{8'h49, 1'b0, mkv(INC, AEOR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[5]  = '{8'h09, 1'b1, mkv(INC, AORA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[6]  = '{8'hE8, 1'b0, mkv(HOLD, AINC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)};
        tbl[7]  = '{8'hD0, 1'b0, mkv(REL, ANOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[8]  = '{8'hD0, 1'b1, mkv(INC, ANOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[9]  = '{8'hF0, 1'b0, mkv(INC, ANOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[10] = '{8'hF0, 1'b1, mkv(REL, ANOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[11] = '{8'hEA, 1'b0, mkv(HOLD, ANOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[12] = '{8'h02, 1'b1, mkv(HOLD, ANOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[13] = '{8'h4C, 1'b0, outv_t'(16'h0000)};
        tbl[14] = '{8'hAD, 1'b0, outv_t'(16'h0000)};
        tbl[15] = '{8'h8D, 1'b1, outv_t'(16'h0000)};
        ops = '{8'hA9, 8'h69, 8'hE9, 8'h29, 8'h49, 8'h09, 8'hE8, 8'hD0, 8'hF0,
                8'hAD, 8'h8D, 8'h4C, 8'hEA};

        rst_n = 1'b0;
        rdy   = 1'b1;
        ir    = 8'hA9;
        zflag = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_v("reset_quiet", outv_t'(16'h0000));
        check_c("reset_icount", 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_v("wait_quiet", outv_t'(16'h0000));
        run_instr(8'hA9, 1'b0, 0, "first_lda");

        // Vector table: fetch and S_EX from the table, trailing cycles from the model
        for (int t = 0; t < 16; t++) begin
            n = model(tbl[t].op, tbl[t].z, seq);
            cyc(1'b1, 8'($urandom), tbl[t].z, seq[0], $sformatf("tbl%0d_fetch", t));
            cyc(1'b1, tbl[t].op, tbl[t].z, tbl[t].ex, $sformatf("tbl%0d_ex_%h", t, tbl[t].op));
            for (int k = 2; k < n; k++)
                cyc(1'b1, tbl[t].op, tbl[t].z, seq[k], $sformatf("tbl%0d_c%0d_%h", t, k, tbl[t].op));
        end

        // STA abs with a 3-cycle stall in S_MEM: write held, no retire until rdy returns
        n = model(8'h8D, 1'b0, seq);
        for (int k = 0; k < 4; k++) cyc(1'b1, 8'h8D, 1'b0, seq[k], "sta_stall_pre");
        repeat (3) cyc(1'b0, 8'h8D, 1'b0, stall_mask(seq[4]), "sta_stall_mem");
        cyc(1'b1, 8'h8D, 1'b0, seq[4], "sta_stall_release");

        // Reset asserted in S_ADH of STA abs
        n = model(8'h8D, 1'b0, seq);
        for (int k = 0; k < 3; k++) cyc(1'b1, 8'h8D, 1'b0, seq[k], "rst_mid_pre");
        @(negedge clk);
        rdy = 1'b1;
        #1;
        check_v("rst_mid_adh", seq[3]);
        #1;
        rst_n = 1'b0;
        #1;
        check_v("rst_mid_quiet", outv_t'(16'h0000));
        check_c("rst_mid_icount", 16'd0);
        exp_icount = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_v("rst_mid_wait", outv_t'(16'h0000));
        run_instr(8'h02, 1'b0, 0, "undef_after_rst");

        // Counter wrap: preset during a fetch cycle, then retire one NOP
        n = model(8'hEA, 1'b0, seq);
        cyc(1'b1, 8'hEA, 1'b0, seq[0], "wrap_fetch");
        #1;
        force dut.icount_r = 16'hFFFF;
        #1;
        release dut.icount_r;
        exp_icount = 16'hFFFF;
        cyc(1'b1, 8'hEA, 1'b0, seq[1], "wrap_ex");
        run_instr(8'hE8, 1'b0, 0, "wrap_after");

        // Randomized instruction stream with random stalls
        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 9) < 7) rop = ops[$urandom_range(0, 12)];
            else rop = 8'($urandom);
            run_instr(rop, 1'($urandom), 20, $sformatf("rand%0d_%h", r, rop));
        end
        cyc(1'b1, 8'hEA, 1'b0, seq[0], "final_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
